// File: rtl/max7219_rx_model.sv
// max7219_rx_model: MAX7219 SPI receiver model with control registers and read port.
// Optional daisy-chain output DOUT is enabled by defining MAX7219_DOUT_EN.
`default_nettype none

module max7219_rx_model (
  input  logic       clk,
  input  logic       res,
  input  logic       MOSI,
  input  logic       CS,
  input  logic       clk_SPI,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       shutdown_n,
  output logic       test,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic [7:0] decode_mode
`ifdef MAX7219_DOUT_EN
  ,
  output logic       DOUT
`endif
);

  // Without DOUT the top nibble is never observed, so only the low 12 bits are kept.
`ifdef MAX7219_DOUT_EN
  localparam int SHIFT_W = 16;
`else
  localparam int SHIFT_W = 12;
`endif

  logic [1:0]         r_cs_s;
  logic [1:0]         r_mosi_s;
  logic [1:0]         r_sck_s;
  logic               r_cs_h;
  logic               r_sck_h;
  logic               r_active;
  logic [4:0]         r_count;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_pend_valid;
  logic               r_pend_err;
  logic [11:0]        r_pend_word;
  logic [7:0]         r_digit [8];

  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sck_rise;
  logic w_cs_low;

  assign w_cs_low   = ~r_cs_s[1];
  assign w_cs_fall  = ~r_cs_s[1] & r_cs_h;
  assign w_cs_rise  = r_cs_s[1] & ~r_cs_h;
  assign w_sck_rise = r_sck_s[1] & ~r_sck_h;

  always_ff @(posedge clk) begin
    if (res) begin
      r_cs_s       <= 2'b11;
      r_cs_h       <= 1'b1;
      r_mosi_s     <= 2'b00;
      r_sck_s      <= 2'b00;
      r_sck_h      <= 1'b0;
      r_active     <= 1'b0;
      r_count      <= 5'd0;
      r_shift      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend_word  <= 12'd0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      frame_addr   <= 4'd0;
      frame_data   <= 8'd0;
      rd_data      <= 8'd0;
      decode_mode  <= 8'd0;
      intensity    <= 4'd0;
      scan_limit   <= 3'd0;
      shutdown_n   <= 1'b0;
      test         <= 1'b0;
      for (int i = 0; i < 8; i++) r_digit[i] <= 8'd0;
    end else begin
      r_cs_s   <= {r_cs_s[0], CS};
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_sck_s  <= {r_sck_s[0], clk_SPI};
      r_cs_h   <= r_cs_s[1];
      r_sck_h  <= r_sck_s[1];

      if (w_cs_fall) begin
        r_active <= 1'b1;
        r_count  <= 5'd0;
      end else if (w_sck_rise && w_cs_low && r_active) begin
        r_shift <= {r_shift[SHIFT_W-2:0], r_mosi_s[1]};
        if (r_count != 5'd31) r_count <= r_count + 5'd1;
      end

      // A CS rise only ends a frame that was opened by a CS fall since reset.
      r_pend_valid <= 1'b0;
      r_pend_err   <= 1'b0;
      if (w_cs_rise && r_active) begin
        r_active     <= 1'b0;
        r_pend_valid <= (r_count == 5'd16);
        r_pend_err   <= (r_count != 5'd16);
        r_pend_word  <= r_shift[11:0];
      end

      frame_valid <= r_pend_valid;
      frame_err   <= r_pend_err;
      if (r_pend_valid) begin
        frame_addr <= r_pend_word[11:8];
        frame_data <= r_pend_word[7:0];
        case (r_pend_word[11:8])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
            r_digit[r_pend_word[10:8] - 3'd1] <= r_pend_word[7:0];
          4'h9:    decode_mode <= r_pend_word[7:0];
          4'hA:    intensity   <= r_pend_word[3:0];
          4'hB:    scan_limit  <= r_pend_word[2:0];
          4'hC:    shutdown_n  <= r_pend_word[0];
          4'hF:    test        <= r_pend_word[0];
          default: ;
        endcase
      end

      case (rd_addr)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                 rd_data <= r_digit[rd_addr[2:0]];
        4'd8:    rd_data <= decode_mode;
        4'd9:    rd_data <= {4'd0, intensity};
        4'd10:   rd_data <= {5'd0, scan_limit};
        4'd11:   rd_data <= {7'd0, shutdown_n};
        4'd12:   rd_data <= {7'd0, test};
        default: rd_data <= 8'd0;
      endcase
    end
  end

`ifdef MAX7219_DOUT_EN
  logic w_sck_fall;
  assign w_sck_fall = ~r_sck_s[1] & r_sck_h;

  always_ff @(posedge clk) begin
    if (res) begin
      DOUT <= 1'b0;
    end else if (w_sck_fall && w_cs_low) begin
      DOUT <= r_shift[SHIFT_W-1];
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/max7219_rx_model.md
MAX7219_RX_MODEL -- requirements
Module: max7219_rx_model

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-002 SHALL have port res, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port MOSI, input, 1: serial data from the SPI driver, asynchronous to clk.
REQ-004 SHALL have port CS, input, 1: frame select, active-low, asynchronous to clk.
REQ-005 SHALL have port clk_SPI, input, 1: serial clock; data sampled on its rising edge; asynchronous to clk.
REQ-006 SHALL have port rd_addr, input, 4: register read address.
REQ-007 SHALL have port rd_data, output, 8: registered read data for rd_addr.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse when a 16-bit frame is committed.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse when a frame ends with a bit count other than 16.
REQ-010 SHALL have port frame_addr, output, 4; frame_data, output, 8: last committed frame fields.
REQ-011 SHALL have ports shutdown_n, test, output, 1 each; intensity, output, 4; scan_limit, output, 3; decode_mode, output, 8: live control-register values.

Function
REQ-012 SHALL pass MOSI, CS and clk_SPI through a 2-flop synchronizer each, then a history flop for edge detection.
REQ-013 SHALL treat a synchronized CS high-to-low transition as frame start: bit counter cleared to 0.
REQ-014 SHALL shift synchronized MOSI into a 16-bit register MSB-first on each synchronized clk_SPI rising edge while synchronized CS is low.
REQ-015 SHALL hold a 5-bit bit counter saturating at 31; edges beyond 31 still shift data.
REQ-016 SHALL, on a synchronized CS low-to-high transition with count == 16, commit the frame: frame_addr = bits[11:8], frame_data = bits[7:0], frame_valid pulses for exactly one cycle.
REQ-017 SHALL, on a CS low-to-high transition with count != 16, pulse frame_err for one cycle and update no register.
REQ-018 SHALL ignore bits[15:12] of a frame.
REQ-019 SHALL decode a committed frame: addr 0 no-op; 1-8 digit register addr-1; 9 decode_mode; 0xA intensity = data[3:0]; 0xB scan_limit = data[2:0]; 0xC shutdown_n = data[0]; 0xF test = data[0]; 0xD, 0xE no-op.
REQ-020 SHALL update the targeted register in the same cycle frame_valid is asserted; outputs reflect the value the following cycle.
REQ-021 SHALL assert frame_valid/frame_err on the 4th rising clk edge after the raw CS rises (edge 1 = first sample of CS high).
REQ-022 SHALL produce rd_data one cycle after rd_addr: 0-7 digits, 8 decode_mode, 9 intensity, 10 scan_limit, 11 shutdown_n, 12 test, 13-15 zero.
REQ-023 SHALL ignore a clk_SPI rising edge seen in the same synchronized cycle as CS rising.
REQ-024 SHALL ignore clk_SPI edges while CS is high, and a CS rising edge without a preceding CS falling edge since reset.
REQ-025 SHALL require clk_SPI high and low phases of at least 3 clk periods each; behaviour with shorter phases is undefined.

Reset
REQ-026 SHALL, with res high at a clk edge, clear all digit registers, decode_mode, intensity, scan_limit, test to 0 and shutdown_n to 0.
REQ-027 SHALL clear rd_data, frame_addr, frame_data, frame_valid, frame_err, bit counter, shift register; synchronizer flops reset to CS = 1, others 0.
REQ-028 SHALL abandon a frame in progress at reset; no commit or error until the next CS falling edge.

Configuration
REQ-029 SHALL, with macro MAX7219_DOUT_EN defined, add output DOUT (1 bit, reset 0) carrying the shift-register MSB, updated on each synchronized clk_SPI falling edge while CS is low, for daisy-chain checking.
REQ-030 SHALL, without MAX7219_DOUT_EN, omit the DOUT port and its logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: frame 0x0A07 -> frame_valid one cycle, frame_addr=0xA, frame_data=0x07, intensity=7.
REQ-032 SHALL cover: frames 0x0105 then 0x0859, rd_addr=0 then 7 -> rd_data 0x05 then 0x59 with 1-cycle latency.
REQ-033 SHALL cover: 15-bit frame then 17-bit frame -> two frame_err pulses, no frame_valid, all registers unchanged.
REQ-034 SHALL cover: res asserted after 8 bits of 0x0C01, then full 0x0C01 -> only second frame commits, shutdown_n=1.
REQ-035 SHALL cover: frame 0x0E55, then 0xFB03 -> no register change for first; scan_limit=3 for second (upper nibble ignored).
REQ-036 SHALL cover, with MAX7219_DOUT_EN: two back-to-back 16-bit frames 0x0A0F, 0x0B02 in one CS window -> frame_err; DOUT during the second 16 bits equals 0x0A0F MSB-first.
